uart_serial_core: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_serial_core_if.sv | 30 +++
 rtl/uart_bit_timer.sv | 43 ++++
 rtl/uart_serial_core.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_serial_core.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared FSM state encoding and bit-timing helper for the UART core.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    function automatic int calc_cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_serial_core_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_serial_core_if
// Purpose  : Pin and byte-stream bundle between the UART core and its host.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_serial_core_if #(
    parameter int PAYLOAD_BITS = 8
);
    logic                    uart_rxd;
    logic                    uart_rx_en;
    logic                    uart_rx_break;
    logic                    uart_rx_valid;
    logic [PAYLOAD_BITS-1:0] uart_rx_data;
    logic                    uart_tx_en;
    logic [PAYLOAD_BITS-1:0] uart_tx_data;
    logic                    uart_txd;
    logic                    uart_tx_busy;

    modport master (
        output uart_rxd, uart_rx_en, uart_tx_en, uart_tx_data,
        input  uart_rx_break, uart_rx_valid, uart_rx_data, uart_txd, uart_tx_busy
    );

    modport slave (
        input  uart_rxd, uart_rx_en, uart_tx_en, uart_tx_data,
        output uart_rx_break, uart_rx_valid, uart_rx_data, uart_txd, uart_tx_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_bit_timer
// Purpose  : Reloadable down-counter; ticks a full or half bit period after load.
// Revision : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
    parameter int CYCLES = 16
) (
    input  logic CLK,
    input  logic reset,
    input  logic i_load_full,
    input  logic i_load_half,
    output logic o_tick
);
    localparam int             c_W    = $clog2(CYCLES + 1);
    localparam logic [c_W-1:0] c_FULL = c_W'(CYCLES - 1);
    localparam logic [c_W-1:0] c_HALF = c_W'(CYCLES / 2 - 1);

    logic [c_W-1:0] r_cnt;
    logic           r_run;

    // A reload wins over an expiring count so back-to-back periods stay exact.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_load_full) begin
            r_cnt <= c_FULL;
            r_run <= 1'b1;
        end else if (i_load_half) begin
            r_cnt <= c_HALF;
            r_run <= 1'b1;
        end else if (r_run) begin
            if (r_cnt == '0) r_run <= 1'b0;
            else             r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tick = r_run && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/uart_serial_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_serial_core
// Purpose  : Full-duplex UART (8N1 default); UART_PARITY_EN adds even parity.
// Revision : 1.0 - initial release
// ============================================================================
module uart_serial_core
    import uart_pkg::*;
#(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 100_000_000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic              CLK,
    input  logic              reset,
    uart_serial_core_if.slave bus
);
    localparam int c_CYCLES = calc_cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int c_CNT_W  = $clog2((PAYLOAD_BITS > STOP_BITS ? PAYLOAD_BITS : STOP_BITS) + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_DATA = c_CNT_W'(PAYLOAD_BITS - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_STOP = c_CNT_W'(STOP_BITS - 1);
`ifdef UART_PARITY_EN
    localparam uart_state_e c_AFTER_DATA = PARITY;
`else
    localparam uart_state_e c_AFTER_DATA = STOP;
`endif

    // ---------------- receiver ----------------
    logic [1:0]              r_rx_sync;
    uart_state_e             r_rx_state, w_rx_nxt;
    logic [PAYLOAD_BITS-1:0] r_rx_shift, r_rx_data;
    logic [c_CNT_W-1:0]      r_rx_cnt;
    logic r_rx_valid, r_rx_break, r_rx_wait_high;
    logic w_rxd, w_rx_tick, w_rx_load_full, w_rx_load_half, w_rx_shift;
    logic w_rx_cnt_clr, w_rx_cnt_inc, w_rx_valid_set, w_rx_break_set, w_rx_wait_high;
    logic w_rx_par_ok, w_rx_all_zero;
`ifdef UART_PARITY_EN
    logic r_rx_par, w_rx_par_cap;
    assign w_rx_par_ok   = ~^{r_rx_shift, r_rx_par};
    assign w_rx_all_zero = (r_rx_shift == '0) && !r_rx_par;
`else
    assign w_rx_par_ok   = 1'b1;
    assign w_rx_all_zero = (r_rx_shift == '0);
`endif

    assign w_rxd = r_rx_sync[1];

    uart_bit_timer #(.CYCLES(c_CYCLES)) u_rx_timer (
        .CLK(CLK), .reset(reset), .i_load_full(w_rx_load_full),
        .i_load_half(w_rx_load_half), .o_tick(w_rx_tick)
    );

    always_ff @(posedge CLK) begin
        if (!reset) r_rx_state <= IDLE;
        else        r_rx_state <= w_rx_nxt;
    end

    always_comb begin
        w_rx_nxt       = r_rx_state;
        w_rx_load_full = 1'b0;
        w_rx_load_half = 1'b0;
        w_rx_shift     = 1'b0;
        w_rx_cnt_clr   = 1'b0;
        w_rx_cnt_inc   = 1'b0;
        w_rx_valid_set = 1'b0;
        w_rx_break_set = 1'b0;
        w_rx_wait_high = 1'b0;
`ifdef UART_PARITY_EN
        w_rx_par_cap   = 1'b0;
`endif
        if (!bus.uart_rx_en) begin
            w_rx_nxt = IDLE;
        end else begin
            unique case (r_rx_state)
                IDLE: if (!w_rxd) begin
                    w_rx_nxt       = START;
                    w_rx_load_half = 1'b1;
                end
                START: if (w_rx_tick) begin
                    if (w_rxd) begin
                        w_rx_nxt = IDLE;
                    end else begin
                        w_rx_nxt       = DATA;
                        w_rx_load_full = 1'b1;
                        w_rx_cnt_clr   = 1'b1;
                    end
                end
                DATA: if (w_rx_tick) begin
                    w_rx_shift     = 1'b1;
                    w_rx_load_full = 1'b1;
                    if (r_rx_cnt == c_LAST_DATA) w_rx_nxt     = c_AFTER_DATA;
                    else                         w_rx_cnt_inc = 1'b1;
                end
`ifdef UART_PARITY_EN
                PARITY: if (w_rx_tick) begin
                    w_rx_par_cap   = 1'b1;
                    w_rx_load_full = 1'b1;
                    w_rx_nxt       = STOP;
                end
`endif
                // Hold here after a low stop bit so a long break cannot retrigger.
                STOP: if (r_rx_wait_high) begin
                    if (w_rxd) w_rx_nxt       = IDLE;
                    else       w_rx_wait_high = 1'b1;
                end else if (w_rx_tick) begin
                    if (w_rxd) begin
                        w_rx_valid_set = w_rx_par_ok;
                        w_rx_nxt       = IDLE;
                    end else begin
                        w_rx_break_set = w_rx_all_zero;
                        w_rx_wait_high = 1'b1;
                    end
                end
                default: w_rx_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_rx_sync      <= 2'b11;
            r_rx_shift     <= '0;
            r_rx_cnt       <= '0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_rx_break     <= 1'b0;
            r_rx_wait_high <= 1'b0;
        end else begin
            r_rx_sync      <= {r_rx_sync[0], bus.uart_rxd};
            r_rx_valid     <= w_rx_valid_set;
            r_rx_break     <= w_rx_break_set;
            r_rx_wait_high <= w_rx_wait_high;
            if (w_rx_shift)     r_rx_shift <= {w_rxd, r_rx_shift[PAYLOAD_BITS-1:1]};
            if (w_rx_valid_set) r_rx_data  <= r_rx_shift;
            if (w_rx_cnt_clr)      r_rx_cnt <= '0;
            else if (w_rx_cnt_inc) r_rx_cnt <= r_rx_cnt + 1'b1;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge CLK) begin
        if (!reset)            r_rx_par <= 1'b0;
        else if (w_rx_par_cap) r_rx_par <= w_rxd;
    end
`endif

    assign bus.uart_rx_valid = r_rx_valid;
    assign bus.uart_rx_break = r_rx_break;
    assign bus.uart_rx_data  = r_rx_data;

    // ---------------- transmitter ----------------
    uart_state_e             r_tx_state, w_tx_nxt;
    logic [PAYLOAD_BITS-1:0] r_tx_shift;
    logic [c_CNT_W-1:0]      r_tx_cnt;
    logic w_tx_tick, w_tx_accept, w_tx_load, w_tx_shift, w_tx_cnt_clr, w_tx_cnt_inc, w_txd;
`ifdef UART_PARITY_EN
    logic r_tx_par;
`endif

    uart_bit_timer #(.CYCLES(c_CYCLES)) u_tx_timer (
        .CLK(CLK), .reset(reset), .i_load_full(w_tx_load),
        .i_load_half(1'b0), .o_tick(w_tx_tick)
    );

    always_ff @(posedge CLK) begin
        if (!reset) r_tx_state <= IDLE;
        else        r_tx_state <= w_tx_nxt;
    end

    always_comb begin
        w_tx_nxt     = r_tx_state;
        w_tx_accept  = 1'b0;
        w_tx_load    = 1'b0;
        w_tx_shift   = 1'b0;
        w_tx_cnt_clr = 1'b0;
        w_tx_cnt_inc = 1'b0;
        unique case (r_tx_state)
            IDLE: if (bus.uart_tx_en) begin
                w_tx_accept = 1'b1;
                w_tx_load   = 1'b1;
                w_tx_nxt    = START;
            end
            START: if (w_tx_tick) begin
                w_tx_load    = 1'b1;
                w_tx_cnt_clr = 1'b1;
                w_tx_nxt     = DATA;
            end
            DATA: if (w_tx_tick) begin
                w_tx_load  = 1'b1;
                w_tx_shift = 1'b1;
                if (r_tx_cnt == c_LAST_DATA) begin
                    w_tx_cnt_clr = 1'b1;
                    w_tx_nxt     = c_AFTER_DATA;
                end else begin
                    w_tx_cnt_inc = 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            PARITY: if (w_tx_tick) begin
                w_tx_load = 1'b1;
                w_tx_nxt  = STOP;
            end
`endif
            STOP: if (w_tx_tick) begin
                if (r_tx_cnt == c_LAST_STOP) begin
                    w_tx_nxt = IDLE;
                end else begin
                    w_tx_load    = 1'b1;
                    w_tx_cnt_inc = 1'b1;
                end
            end
            default: w_tx_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_txd = 1'b1;
        unique case (r_tx_state)
            START:   w_txd = 1'b0;
            DATA:    w_txd = r_tx_shift[0];
`ifdef UART_PARITY_EN
            PARITY:  w_txd = r_tx_par;
`endif
            default: w_txd = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_tx_shift <= '0;
            r_tx_cnt   <= '0;
        end else begin
            if (w_tx_accept)     r_tx_shift <= bus.uart_tx_data;
            else if (w_tx_shift) r_tx_shift <= {1'b0, r_tx_shift[PAYLOAD_BITS-1:1]};
            if (w_tx_cnt_clr)      r_tx_cnt <= '0;
            else if (w_tx_cnt_inc) r_tx_cnt <= r_tx_cnt + 1'b1;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge CLK) begin
        if (!reset)           r_tx_par <= 1'b0;
        else if (w_tx_accept) r_tx_par <= ^bus.uart_tx_data;
    end
`endif

    assign bus.uart_txd     = w_txd;
    assign bus.uart_tx_busy = (r_tx_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_serial_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_serial_core
// Purpose  : Randomised self-checking bench for uart_serial_core (fast bit clock).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_serial_core;
    localparam int c_CLK_HZ   = 1_600_000;
    localparam int c_BIT_RATE = 100_000;
    localparam int c_CPB      = c_CLK_HZ / c_BIT_RATE;
    localparam int c_HALF     = c_CPB / 2;
`ifdef UART_PARITY_EN
    localparam int c_FL = 11;
`else
    localparam int c_FL = 10;
`endif

    logic CLK   = 1'b0;
    logic reset = 1'b0;
    logic r_loop    = 1'b0;
    logic r_rxd_drv = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] q_valid[$];
    int         n_break = 0;
    int         n_wide  = 0;
    logic       prev_v  = 1'b0;
    logic       prev_b  = 1'b0;
    logic [7:0] exp_data = 8'h00;

    uart_serial_core_if #(.PAYLOAD_BITS(8)) bus();

    assign bus.uart_rxd = r_loop ? bus.uart_txd : r_rxd_drv;

    uart_serial_core #(
        .BIT_RATE(c_BIT_RATE), .CLK_HZ(c_CLK_HZ), .PAYLOAD_BITS(8), .STOP_BITS(1)
    ) dut (
        .CLK(CLK), .reset(reset), .bus(bus)
    );

    always #5 CLK = ~CLK;

    // Record every receiver pulse; a pulse lasting two cycles is counted as wide.
    always @(negedge CLK) begin
        if (bus.uart_rx_valid === 1'b1) q_valid.push_back(bus.uart_rx_data);
        if (bus.uart_rx_break === 1'b1) n_break++;
        if ((bus.uart_rx_valid === 1'b1 && prev_v) || (bus.uart_rx_break === 1'b1 && prev_b)) n_wide++;
        prev_v = (bus.uart_rx_valid === 1'b1);
        prev_b = (bus.uart_rx_break === 1'b1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Line levels of one frame, index 0 is the start bit.
    function automatic logic [c_FL-1:0] frame_bits(input logic [7:0] d, input logic stop_v);
`ifdef UART_PARITY_EN
        return {stop_v, ^d, d, 1'b0};
`else
        return {stop_v, d, 1'b0};
`endif
    endfunction

    task automatic clear_mon();
        q_valid.delete();
        n_break = 0;
        n_wide  = 0;
    endtask

    task automatic send_rx_frame(input logic [7:0] d, input logic stop_v);
        logic [c_FL-1:0] f;
        f = frame_bits(d, stop_v);
        for (int k = 0; k < c_FL; k++) begin
            r_rxd_drv = f[k];
            step(c_CPB);
        end
        r_rxd_drv = 1'b1;
        step(2 * c_CPB);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(3);
        n_vec++; if (bus.uart_txd !== 1'b1) begin n_err++; $display("FAIL reset_txd: got %b want 1", bus.uart_txd); end
        n_vec++; if (bus.uart_tx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.uart_tx_busy); end
        n_vec++; if (bus.uart_rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.uart_rx_valid); end
        n_vec++; if (bus.uart_rx_break !== 1'b0) begin n_err++; $display("FAIL reset_break: got %b want 0", bus.uart_rx_break); end
        n_vec++; if (bus.uart_rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", bus.uart_rx_data); end
        reset = 1'b1;
        step(2);
        n_vec++; if (bus.uart_txd !== 1'b1) begin n_err++; $display("FAIL post_reset_txd: got %b want 1", bus.uart_txd); end
    endtask

    task automatic test_tx_frame(input logic [7:0] d, input bit misuse);
        logic [c_FL-1:0] f;
        int bad, busy_cyc, idle_bad;
        f = frame_bits(d, 1'b1);
        busy_cyc = 0;
        bus.uart_tx_data = d;
        bus.uart_tx_en   = 1'b1;
        n_vec++; if (bus.uart_tx_busy !== 1'b0) begin n_err++; $display("FAIL tx_busy_pre: got %b want 0", bus.uart_tx_busy); end
        step(1);
        bus.uart_tx_en   = 1'b0;
        bus.uart_tx_data = 8'($urandom);
        for (int k = 0; k < c_FL; k++) begin
            bad = 0;
            for (int j = 0; j < c_CPB; j++) begin
                if (bus.uart_txd !== f[k]) bad++;
                if (bus.uart_tx_busy === 1'b1) busy_cyc++;
                if (misuse && k == 4 && j == c_HALF) begin
                    bus.uart_tx_en   = 1'b1;
                    bus.uart_tx_data = 8'hFF;
                end else begin
                    bus.uart_tx_en = 1'b0;
                end
                step(1);
            end
            n_vec++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL tx_bit[%0d] byte %h: got %0d wrong cycles want 0 (level %b)", k, d, bad, f[k]);
            end
        end
        n_vec++; if (busy_cyc != c_FL * c_CPB) begin n_err++; $display("FAIL tx_busy_len: got %0d want %0d", busy_cyc, c_FL * c_CPB); end
        n_vec++; if (bus.uart_tx_busy !== 1'b0) begin n_err++; $display("FAIL tx_busy_drop: got %b want 0", bus.uart_tx_busy); end
        idle_bad = 0;
        repeat (2 * c_CPB) begin
            if (bus.uart_tx_busy !== 1'b0 || bus.uart_txd !== 1'b1) idle_bad++;
            step(1);
        end
        n_vec++; if (idle_bad != 0) begin n_err++; $display("FAIL tx_idle_after: got %0d active cycles want 0", idle_bad); end
    endtask

    task automatic test_back_to_back(input logic [7:0] a, input logic [7:0] b);
        int  waited;
        bit  dropped;
        r_loop = 1'b1;
        clear_mon();
        bus.uart_tx_data = a;
        bus.uart_tx_en   = 1'b1;
        step(1);
        bus.uart_tx_data = b;
        waited  = 0;
        dropped = 0;
        while (!dropped && waited < c_FL * c_CPB + 8) begin
            if (bus.uart_tx_busy === 1'b0) dropped = 1;
            else begin step(1); waited++; end
        end
        n_vec++;
        if (!dropped || waited != c_FL * c_CPB) begin
            n_err++;
            $display("FAIL b2b_first_len: got %0d cycles (dropped=%0d) want %0d", waited, dropped, c_FL * c_CPB);
        end
        step(1);
        bus.uart_tx_en = 1'b0;
        n_vec++; if (bus.uart_tx_busy !== 1'b1) begin n_err++; $display("FAIL b2b_second_accept: got busy %b want 1", bus.uart_tx_busy); end
        step(c_FL * c_CPB + 3 * c_CPB);
        n_vec++; if (q_valid.size() != 2) begin n_err++; $display("FAIL b2b_valid_count: got %0d want 2", q_valid.size()); end
        if (q_valid.size() == 2) begin
            n_vec++; if (q_valid[0] !== a) begin n_err++; $display("FAIL b2b_data0: got %h want %h", q_valid[0], a); end
            n_vec++; if (q_valid[1] !== b) begin n_err++; $display("FAIL b2b_data1: got %h want %h", q_valid[1], b); end
            exp_data = b;
        end
        n_vec++; if (n_break != 0) begin n_err++; $display("FAIL b2b_break: got %0d want 0", n_break); end
        n_vec++; if (n_wide != 0) begin n_err++; $display("FAIL b2b_pulse_width: got %0d wide pulses want 0", n_wide); end
        r_loop = 1'b0;
    endtask

    task automatic test_rx_frames();
        logic [7:0] d;
        logic       sv;
        int         want_v, want_b;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      begin d = 8'h3C; sv = 1'b0; end
            else if (i == 1) begin d = 8'h7E; sv = 1'b1; end
            else begin
                d  = (i == 5) ? 8'h00 : 8'($urandom);
                sv = ($urandom_range(0, 3) != 0);
            end
            want_v = sv ? 1 : 0;
            want_b = (!sv && d == 8'h00) ? 1 : 0;
            clear_mon();
            send_rx_frame(d, sv);
            if (want_v == 1) exp_data = d;
            n_vec++; if (q_valid.size() != want_v) begin n_err++; $display("FAIL rx_valid_count byte %h stop %b: got %0d want %0d", d, sv, q_valid.size(), want_v); end
            if (want_v == 1 && q_valid.size() == 1) begin
                n_vec++; if (q_valid[0] !== d) begin n_err++; $display("FAIL rx_data_pulse: got %h want %h", q_valid[0], d); end
            end
            n_vec++; if (n_break != want_b) begin n_err++; $display("FAIL rx_break_count byte %h stop %b: got %0d want %0d", d, sv, n_break, want_b); end
            n_vec++; if (bus.uart_rx_data !== exp_data) begin n_err++; $display("FAIL rx_data_hold: got %h want %h", bus.uart_rx_data, exp_data); end
        end
    endtask

    task automatic test_break();
        clear_mon();
        r_rxd_drv = 1'b0;
        step(15 * c_CPB);
        r_rxd_drv = 1'b1;
        step(3 * c_CPB);
        n_vec++; if (n_break != 1) begin n_err++; $display("FAIL break_count: got %0d want 1", n_break); end
        n_vec++; if (q_valid.size() != 0) begin n_err++; $display("FAIL break_valid: got %0d want 0", q_valid.size()); end
        n_vec++; if (bus.uart_rx_data !== exp_data) begin n_err++; $display("FAIL break_data: got %h want %h", bus.uart_rx_data, exp_data); end
        n_vec++; if (n_wide != 0) begin n_err++; $display("FAIL break_width: got %0d wide want 0", n_wide); end
    endtask

    task automatic test_glitch();
        int widths[3];
        widths = '{1, 3, c_HALF - 2};
        foreach (widths[i]) begin
            clear_mon();
            r_rxd_drv = 1'b0;
            step(widths[i]);
            r_rxd_drv = 1'b1;
            step(2 * c_CPB);
            n_vec++; if (q_valid.size() != 0 || n_break != 0) begin
                n_err++;
                $display("FAIL glitch_%0d: got %0d valid %0d break want 0 0", widths[i], q_valid.size(), n_break);
            end
        end
    endtask

    task automatic test_rx_disable();
        logic [c_FL-1:0] f;
        f = frame_bits(8'h5A, 1'b1);
        clear_mon();
        for (int k = 0; k < c_FL; k++) begin
            r_rxd_drv = f[k];
            if (k == 4) bus.uart_rx_en = 1'b0;
            step(c_CPB);
        end
        r_rxd_drv = 1'b1;
        step(2 * c_CPB);
        bus.uart_rx_en = 1'b1;
        step(c_CPB);
        n_vec++; if (q_valid.size() != 0 || n_break != 0) begin n_err++; $display("FAIL rx_disable_pulses: got %0d valid %0d break want 0 0", q_valid.size(), n_break); end
        n_vec++; if (bus.uart_rx_data !== exp_data) begin n_err++; $display("FAIL rx_disable_data: got %h want %h", bus.uart_rx_data, exp_data); end
    endtask

    task automatic test_reset_midframe();
        clear_mon();
        bus.uart_tx_data = 8'($urandom);
        bus.uart_tx_en   = 1'b1;
        step(1);
        bus.uart_tx_en = 1'b0;
        r_rxd_drv = 1'b0;
        step(3 * c_CPB + 5);
        reset     = 1'b0;
        r_rxd_drv = 1'b1;
        step(1);
        reset    = 1'b1;
        exp_data = 8'h00;
        n_vec++; if (bus.uart_txd !== 1'b1) begin n_err++; $display("FAIL midreset_txd: got %b want 1", bus.uart_txd); end
        n_vec++; if (bus.uart_tx_busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b want 0", bus.uart_tx_busy); end
        n_vec++; if (bus.uart_rx_valid !== 1'b0) begin n_err++; $display("FAIL midreset_valid: got %b want 0", bus.uart_rx_valid); end
        n_vec++; if (bus.uart_rx_data !== exp_data) begin n_err++; $display("FAIL midreset_data: got %h want %h", bus.uart_rx_data, exp_data); end
        step(3 * c_CPB);
        n_vec++; if (q_valid.size() != 0 || n_break != 0 || bus.uart_tx_busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_quiet: got %0d valid %0d break busy %b want 0 0 0", q_valid.size(), n_break, bus.uart_tx_busy);
        end
        clear_mon();
        send_rx_frame(8'h81, 1'b1);
        n_vec++; if (q_valid.size() != 1) begin n_err++; $display("FAIL post_reset_count: got %0d want 1", q_valid.size()); end
        if (q_valid.size() == 1) begin
            n_vec++; if (q_valid[0] !== 8'h81) begin n_err++; $display("FAIL post_reset_data: got %h want 81", q_valid[0]); end
        end
        exp_data = 8'h81;
    endtask

    initial begin
        bus.uart_rx_en   = 1'b1;
        bus.uart_tx_en   = 1'b0;
        bus.uart_tx_data = 8'h00;
        test_reset();
        test_tx_frame(8'h55, 1'b0);
        test_tx_frame(8'($urandom), 1'b0);
        test_tx_frame(8'($urandom), 1'b1);
        test_back_to_back(8'hA3, 8'h00);
        test_back_to_back(8'($urandom), 8'($urandom));
        test_rx_frames();
        test_break();
        test_glitch();
        test_rx_disable();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
